// File: rtl/tia_pkg.sv
// rtl/tia_pkg.sv - shared phase-state encoding for TIA biphase cells
package tia_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } phase_e;

    function automatic phase_e next_phase(input phase_e s);
        case (s)
            S0:      next_phase = S1;
            S1:      next_phase = S2;
            S2:      next_phase = S3;
            default: next_phase = S0;
        endcase
    endfunction

endpackage

// File: rtl/tia_d2_stage_if.sv
// rtl/tia_d2_stage_if.sv - data inputs and phase/latch outputs of the D2 cell
interface tia_d2_stage_if;
    logic in1;
    logic in2;
    logic phi1;
    logic phi2;
    logic rl;
    logic tap;
    logic out;

    modport master (
        output in1, in2,
        input  phi1, phi2, rl, tap, out
    );

    modport slave (
        input  in1, in2,
        output phi1, phi2, rl, tap, out
    );
endinterface

// File: rtl/tia_biphase_clock.sv
// rtl/tia_biphase_clock.sv - four-state counter producing non-overlapping phi1/phi2
import tia_pkg::*;

module tia_biphase_clock (
    input  logic clk,
    input  logic r,
    output logic phi1_o,
    output logic phi2_o,
    output logic rl_o
);

    phase_e st_q;
    phase_e st_d;
    logic   phi1_q;
    logic   phi2_q;
    logic   rl_q;

    // next phase is a plain rotation S0->S1->S2->S3->S0
    always_comb begin
        st_d = next_phase(st_q);
    end

    // phases are loaded from the decode of the next state so they never glitch
    always_ff @(posedge clk) begin
        if (r) begin
            st_q   <= S3;
            phi1_q <= 1'b0;
            phi2_q <= 1'b0;
            rl_q   <= 1'b1;
        end else begin
            st_q   <= st_d;
            phi1_q <= (st_d == S0);
            phi2_q <= (st_d == S2);
            if (st_d == S0) begin
                rl_q <= 1'b0;
            end
        end
    end

    assign phi1_o = phi1_q;
    assign phi2_o = phi2_q;
    assign rl_o   = rl_q;

endmodule

// File: rtl/tia_d2_stage.sv
// rtl/tia_d2_stage.sv - D2 delay cell: NOR into phi1 latch, inverted into phi2 latch
module tia_d2_stage (
    input  logic           clk,
    input  logic           r,
    tia_d2_stage_if.slave  bus
);

    logic phi1;
    logic phi2;
    logic rl;
    logic tap_q;
    logic tap_d;
    logic out_q;
    logic out_d;

    tia_biphase_clock u_clk (
        .clk    (clk),
        .r      (r),
        .phi1_o (phi1),
        .phi2_o (phi2),
        .rl_o   (rl)
    );

    // latches modelled as flop + bypass mux: transparent while their phase is high
    always_comb begin
        tap_d = phi1 ? ~(bus.in1 | bus.in2) : tap_q;
        out_d = phi2 ? ~tap_q : out_q;
    end

    // latch storage follows the mux output every clock; reset leaves tap=1, out=0
    always_ff @(posedge clk) begin
        if (r) begin
            tap_q <= 1'b1;
            out_q <= 1'b0;
        end else begin
            tap_q <= tap_d;
            out_q <= out_d;
        end
    end

    assign bus.phi1 = phi1;
    assign bus.phi2 = phi2;
    assign bus.rl   = rl;
    assign bus.tap  = tap_d;
    assign bus.out  = out_d;

endmodule

// File: tb/tb_tia_d2_stage.sv
// tb/tb_tia_d2_stage.sv - table, corner-case and random checks of tia_d2_stage
module tb_tia_d2_stage;

    logic clk = 1'b0;
    logic r   = 1'b1;

    tia_d2_stage_if bus ();

    tia_d2_stage dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference: phase index within the phi cycle plus the value each latch holds
    int   m_ph  = 3;
    logic m_tap = 1'b1;
    logic m_out = 1'b0;
    logic m_rl  = 1'b1;

    typedef struct {
        logic r;
        logic a;
        logic b;
        logic phi1;
        logic phi2;
        logic rl;
        logic tap;
        logic out;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rr, input logic a, input logic b);
        @(negedge clk);
        r       = rr;
        bus.in1 = a;
        bus.in2 = b;
    endtask

    // one clock edge of the reference, using the inputs present before the edge
    task automatic model_edge();
        if (r) begin
            m_ph  = 3;
            m_tap = 1'b1;
            m_out = 1'b0;
            m_rl  = 1'b1;
        end else begin
            if (m_ph == 0) m_tap = ~(bus.in1 | bus.in2);
            if (m_ph == 2) m_out = ~m_tap;
            m_ph = (m_ph + 1) % 4;
            if (m_ph == 0) m_rl = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic e_tap;
        logic e_out;
        e_tap = (m_ph == 0) ? ~(bus.in1 | bus.in2) : m_tap;
        e_out = (m_ph == 2) ? ~m_tap : m_out;
        chk({tag, " phi1"}, bus.phi1, logic'(m_ph == 0));
        chk({tag, " phi2"}, bus.phi2, logic'(m_ph == 2));
        chk({tag, " rl"},   bus.rl,   m_rl);
        chk({tag, " tap"},  bus.tap,  e_tap);
        chk({tag, " out"},  bus.out,  e_out);
    endtask

    initial begin
        bus.in1 = 1'b0;
        bus.in2 = 1'b0;

        //                r  a  b  phi1 phi2 rl tap out
        tbl.push_back('{1, 0, 0, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 1, 0});
        // in1 for one phi cycle, then zeros
        tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0});
        // in2 alone gives the same result
        tbl.push_back('{0, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 1});
        // both high, held output stays 1
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{0, 1, 1, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 1});
        // back to zeros
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0});

        foreach (tbl[i]) begin
            string n;
            drive(tbl[i].r, tbl[i].a, tbl[i].b);
            tick();
            n = $sformatf("tbl%0d", i);
            chk({n, " phi1"}, bus.phi1, tbl[i].phi1);
            chk({n, " phi2"}, bus.phi2, tbl[i].phi2);
            chk({n, " rl"},   bus.rl,   tbl[i].rl);
            chk({n, " tap"},  bus.tap,  tbl[i].tap);
            chk({n, " out"},  bus.out,  tbl[i].out);
        end

        // reset asserted while phi2 is high and out=1 aborts the phi cycle
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        chk("pre-abort phi2", bus.phi2, 1'b1);
        chk("pre-abort out",  bus.out,  1'b1);
        drive(1'b1, 1'b1, 1'b0);
        tick();
        chk("abort phi2", bus.phi2, 1'b0);
        chk("abort phi1", bus.phi1, 1'b0);
        chk("abort rl",   bus.rl,   1'b1);
        chk("abort tap",  bus.tap,  1'b1);
        chk("abort out",  bus.out,  1'b0);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        chk("restart phi1", bus.phi1, 1'b1);
        chk("restart rl",   bus.rl,   1'b0);
        chk("restart out",  bus.out,  1'b0);
        chk("restart tap",  bus.tap,  1'b1);

        // random inputs changing on the falling edge, occasional reset
        for (int k = 0; k < 400; k++) begin
            drive(logic'($urandom_range(0, 39) == 0),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)));
            #1;
            check_model($sformatf("rnd%0d mid", k));
            tick();
            check_model($sformatf("rnd%0d edge", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
